hbridge_guard: RTL and testbench

HBRIDGE_GUARD -- requirements
Module: hbridge_guard

---
 rtl/hb_pkg.sv | 26 ++
 rtl/hb_channel.sv | 138 +++++++++++++
 rtl/hbridge_guard.sv | 75 +++++++
 tb/tb_hbridge_guard.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hb_pkg.sv
// Shared definitions for the H-bridge guard.
// Holds the per-channel state enum, the direction pin codes and the
// default cycle counts used by hbridge_guard and hb_channel.
package hb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_FAULT = 2'd3
  } hb_state_e;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_COAST = 2'b00;

  // 0.5 ms coast and 100 ms fault hold at 100 MHz
  localparam int DEAD_CYC_DEF  = 50_000;
  localparam int RETRY_CYC_DEF = 10_000_000;

  // Only 10 and 01 drive the bridge; 00 and 11 both mean coast.
  function automatic logic is_drive(input logic [1:0] code);
    return (code == DIR_FWD) || (code == DIR_REV);
  endfunction

endpackage

// File: rtl/hb_channel.sv
// One H-bridge channel guard: sequences drive, coast (dead time) and
// overcurrent fault hold for a single motor.
// Ports:
//   clk, rst_n    system clock, async active-low reset
//   req           2-bit direction request (10/01 drive, 00/11 coast)
//   en_req        PWM enable request
//   oc_sync       synchronized overcurrent flag
//   dir_out       registered direction pins
//   en_out        registered enable pin
//   fault         registered fault indicator
//   hold_nxt      next state is DEAD or FAULT (for the top-level busy flop)
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | bridge off, waiting for a drive request
// ST_RUN   | driving in the latched direction, en follows en_req
// ST_DEAD  | forced coast for DEAD_CYC cycles after stop/reversal
// ST_FAULT | overcurrent hold, re-arms after a RETRY_CYC window
module hb_channel
  import hb_pkg::*;
#(
  parameter int DEAD_CYC  = DEAD_CYC_DEF,
  parameter int RETRY_CYC = RETRY_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en_req,
  input  logic       oc_sync,
  output logic [1:0] dir_out,
  output logic       en_out,
  output logic       fault,
  output logic       hold_nxt
);

  localparam int MAX_CYC = (DEAD_CYC > RETRY_CYC) ? DEAD_CYC : RETRY_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] DEAD_LOAD  = CW'((DEAD_CYC  > 0) ? DEAD_CYC  - 1 : 0);
  localparam logic [CW-1:0] RETRY_LOAD = CW'((RETRY_CYC > 0) ? RETRY_CYC - 1 : 0);

  hb_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    dir_lat, dir_nxt;
  logic [1:0]    dir_d;
  logic          en_d, fault_d;

  // Outputs are registered from the next state, so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      dir_lat <= DIR_COAST;
      dir_out <= DIR_COAST;
      en_out  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dir_lat <= dir_nxt;
      dir_out <= dir_d;
      en_out  <= en_d;
      fault   <= fault_d;
    end
  end

  // The timer loads N-1 on entry and stops at zero, so the zero check
  // is both the expiry and the saturation point.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir_lat;
    if (oc_sync && (state != ST_FAULT)) begin
      state_nxt = ST_FAULT;
      cnt_nxt   = RETRY_LOAD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_drive(req)) begin
            state_nxt = ST_RUN;
            dir_nxt   = req;
          end
        end
        ST_RUN: begin
          if (req != dir_lat) begin
            state_nxt = ST_DEAD;
            cnt_nxt   = DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          if (cnt == '0) begin
            if (is_drive(req)) begin
              state_nxt = ST_RUN;
              dir_nxt   = req;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ST_FAULT: begin
          if (cnt == '0) begin
            if (oc_sync) begin
              cnt_nxt = RETRY_LOAD;
            end else begin
              state_nxt = ST_DEAD;
              cnt_nxt   = DEAD_LOAD;
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dir_d    = DIR_COAST;
    en_d     = 1'b0;
    fault_d  = 1'b0;
    hold_nxt = 1'b0;
    case (state_nxt)
      ST_RUN: begin
        dir_d = dir_nxt;
        en_d  = en_req;
      end
      ST_DEAD:  hold_nxt = 1'b1;
      ST_FAULT: begin
        fault_d  = 1'b1;
        hold_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hbridge_guard.sv
// Dual H-bridge guard: two independent channel guards (motor A on the
// upper bits, motor B on the lower bits), overcurrent synchronizers and
// the shared busy flag.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   dir_req     [3:2] motor A, [1:0] motor B direction request
//   en_req      [1] motor A, [0] motor B enable request
//   oc          async overcurrent flags, [1] A, [0] B
//   dir_out     H-bridge direction pins
//   en_out      H-bridge enable pins
//   fault       per-motor fault indicator
//   busy        any channel in DEAD or FAULT
module hbridge_guard
  import hb_pkg::*;
#(
  parameter int DEAD_CYC  = DEAD_CYC_DEF,
  parameter int RETRY_CYC = RETRY_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dir_req,
  input  logic [1:0] en_req,
  input  logic [1:0] oc,
  output logic [3:0] dir_out,
  output logic [1:0] en_out,
  output logic [1:0] fault,
  output logic       busy
);

  logic [1:0] oc_s1, oc_s2;
  logic       hold_a, hold_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc_s1 <= 2'b00;
      oc_s2 <= 2'b00;
      busy  <= 1'b0;
    end else begin
      oc_s1 <= oc;
      oc_s2 <= oc_s1;
      busy  <= hold_a | hold_b;
    end
  end

  hb_channel #(
    .DEAD_CYC (DEAD_CYC),
    .RETRY_CYC(RETRY_CYC)
  ) u_chan_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (dir_req[3:2]),
    .en_req  (en_req[1]),
    .oc_sync (oc_s2[1]),
    .dir_out (dir_out[3:2]),
    .en_out  (en_out[1]),
    .fault   (fault[1]),
    .hold_nxt(hold_a)
  );

  hb_channel #(
    .DEAD_CYC (DEAD_CYC),
    .RETRY_CYC(RETRY_CYC)
  ) u_chan_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (dir_req[1:0]),
    .en_req  (en_req[0]),
    .oc_sync (oc_s2[0]),
    .dir_out (dir_out[1:0]),
    .en_out  (en_out[0]),
    .fault   (fault[0]),
    .hold_nxt(hold_b)
  );

endmodule

// File: tb/tb_hbridge_guard.sv
// Bench for hbridge_guard: directed scenarios plus randomized segments,
// with a time-based reference model feeding an expectation queue that a
// separate monitor drains every clock.
module tb_hbridge_guard;

  localparam int DEAD  = 8;
  localparam int RETRY = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dir_req = 4'b0000;
  logic [1:0] en_req = 2'b00;
  logic [1:0] oc = 2'b00;
  logic [3:0] dir_out;
  logic [1:0] en_out;
  logic [1:0] fault;
  logic       busy;

  hbridge_guard #(
    .DEAD_CYC (DEAD),
    .RETRY_CYC(RETRY)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dir_req(dir_req),
    .en_req (en_req),
    .oc     (oc),
    .dir_out(dir_out),
    .en_out (en_out),
    .fault  (fault),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dir;
    logic [1:0] en;
    logic [1:0] flt;
    logic       bsy;
  } obs_t;

  obs_t exp_q[$];
  int   n_run = 0;
  int   n_fail = 0;

  function automatic void check(input string nm, input int act, input int req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endfunction

  // Reference model: each motor is stopped, driving, coasting until an
  // absolute edge number, or tripped since an edge number.
  localparam int M_STOP = 0, M_DRIVE = 1, M_COAST = 2, M_TRIP = 3;
  int         mode[2];
  logic [1:0] held[2];
  int         coast_end[2];
  int         trip_start[2];
  int         tnow = 0;
  logic [1:0] seen_1 = 2'b00, seen_2 = 2'b00;

  function automatic obs_t model_edge(input logic r, input logic [3:0] d,
                                      input logic [1:0] e, input logic [1:0] o);
    obs_t       res;
    logic [1:0] seen;
    logic [1:0] q;
    logic       want;
    res = '0;
    if (!r) begin
      for (int ch = 0; ch < 2; ch++) mode[ch] = M_STOP;
      seen_1 = 2'b00;
      seen_2 = 2'b00;
      return res;
    end
    tnow++;
    seen   = seen_2;
    seen_2 = seen_1;
    seen_1 = o;
    for (int ch = 0; ch < 2; ch++) begin
      q    = (ch == 1) ? d[3:2] : d[1:0];
      want = (q == 2'b10) || (q == 2'b01);
      if (seen[ch] && mode[ch] != M_TRIP) begin
        mode[ch]       = M_TRIP;
        trip_start[ch] = tnow;
      end else if (mode[ch] == M_STOP) begin
        if (want) begin
          mode[ch] = M_DRIVE;
          held[ch] = q;
        end
      end else if (mode[ch] == M_DRIVE) begin
        if (q != held[ch]) begin
          mode[ch]      = M_COAST;
          coast_end[ch] = tnow + DEAD;
        end
      end else if (mode[ch] == M_COAST) begin
        if (tnow == coast_end[ch]) begin
          mode[ch] = want ? M_DRIVE : M_STOP;
          if (want) held[ch] = q;
        end
      end else begin
        if ((tnow - trip_start[ch]) % RETRY == 0 && !seen[ch]) begin
          mode[ch]      = M_COAST;
          coast_end[ch] = tnow + DEAD;
        end
      end
      if (mode[ch] == M_DRIVE) begin
        if (ch == 1) res.dir[3:2] = held[ch];
        else         res.dir[1:0] = held[ch];
        res.en[ch] = e[ch];
      end
      if (mode[ch] == M_TRIP) res.flt[ch] = 1'b1;
      if (mode[ch] == M_COAST || mode[ch] == M_TRIP) res.bsy = 1'b1;
    end
    return res;
  endfunction

  // Monitor: one expectation per clock edge.
  initial begin
    forever begin
      obs_t ex, ac;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        ac = {dir_out, en_out, fault, busy};
        check("outputs", int'(ac), int'(ex));
      end
    end
  end

  task automatic cycle(input logic r, input logic [3:0] d, input logic [1:0] e,
                       input logic [1:0] o);
    @(negedge clk);
    dir_req = d;
    en_req  = e;
    oc      = o;
    if (!r && rst_n) begin
      rst_n = 1'b0;
      #1;
      check("async_reset", int'({dir_out, en_out, fault, busy}), 0);
    end else begin
      rst_n = r;
    end
    exp_q.push_back(model_edge(r, d, e, o));
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  int         bcnt, fcnt, first_f;
  bit         ok_a, ok_b;
  int         len;
  logic [3:0] rd;
  logic [1:0] re, ro;

  initial begin
    repeat (3) cycle(0, 4'b0000, 2'b00, 2'b00);

    // Drive start
    cycle(1, 4'b1001, 2'b11, 2'b00);
    sample();
    check("start_dir", int'(dir_out), 4'b1001);
    check("start_en", int'(en_out), 2'b11);
    check("start_busy", int'(busy), 0);

    // Reversal of motor B
    bcnt = 0; ok_a = 1; ok_b = 1;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 4'b1010, 2'b11, 2'b00);
      sample();
      if (busy) bcnt++;
      if (dir_out[3:2] != 2'b10) ok_a = 0;
      if (busy && (dir_out[1:0] != 2'b00 || en_out[0])) ok_b = 0;
    end
    check("rev_busy_cycles", bcnt, DEAD);
    check("rev_a_held", int'(ok_a), 1);
    check("rev_b_coast", int'(ok_b), 1);
    check("rev_final_dir", int'(dir_out), 4'b1010);

    // Code 11 is coast
    repeat (2) cycle(0, 4'b0000, 2'b00, 2'b00);
    ok_a = 1;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 4'b1111, 2'b11, 2'b00);
      sample();
      if (dir_out != 4'b0000 || en_out != 2'b00) ok_a = 0;
    end
    check("code11_coast", int'(ok_a), 1);

    // Overcurrent pulse on motor A
    repeat (2) cycle(0, 4'b0000, 2'b00, 2'b00);
    repeat (3) cycle(1, 4'b1001, 2'b11, 2'b00);
    fcnt = 0; bcnt = 0; ok_b = 1; first_f = -1;
    for (int i = 0; i < 43; i++) begin
      cycle(1, 4'b1001, 2'b11, (i < 3) ? 2'b10 : 2'b00);
      sample();
      if (fault[1]) begin
        fcnt++;
        if (first_f < 0) first_f = i;
        if (dir_out[3:2] != 2'b00) ok_b = 0;
      end
      if (busy) bcnt++;
      if (dir_out[1:0] != 2'b01 || !en_out[0]) ok_b = 0;
    end
    check("oc_a_first_fault", first_f, 2);
    check("oc_a_fault_cycles", fcnt, RETRY);
    check("oc_a_busy_cycles", bcnt, RETRY + DEAD);
    check("oc_a_b_unaffected", int'(ok_b), 1);
    check("oc_a_rearmed", int'(dir_out), 4'b1001);

    // Long overcurrent on motor B
    repeat (2) cycle(0, 4'b0000, 2'b00, 2'b00);
    repeat (3) cycle(1, 4'b1001, 2'b11, 2'b00);
    fcnt = 0;
    for (int i = 0; i < 80; i++) begin
      cycle(1, 4'b1001, 2'b11, (i < 40) ? 2'b01 : 2'b00);
      sample();
      if (fault[0]) fcnt++;
    end
    check("oc_b_fault_cycles", fcnt, 3 * RETRY);
    check("oc_b_rearmed", int'(dir_out), 4'b1001);

    // Reset in the middle of dead time
    repeat (2) cycle(0, 4'b0000, 2'b00, 2'b00);
    repeat (3) cycle(1, 4'b1001, 2'b11, 2'b00);
    repeat (4) cycle(1, 4'b0001, 2'b11, 2'b00);
    sample();
    check("mid_dead_busy", int'(busy), 1);
    repeat (2) cycle(0, 4'b0110, 2'b11, 2'b00);
    cycle(1, 4'b0110, 2'b11, 2'b00);
    sample();
    check("post_reset_dir", int'(dir_out), 4'b0110);
    check("post_reset_busy", int'(busy), 0);

    // Randomized segments
    for (int s = 0; s < 160; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        repeat (2) cycle(0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00);
      end
      len = $urandom_range(1, 20);
      rd  = 4'($urandom_range(0, 15));
      re  = 2'($urandom_range(0, 3));
      ro  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      for (int i = 0; i < len; i++) cycle(1, rd, re, ro);
    end

    repeat (3) sample();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
